// File: rtl/apb_i2c_sequencer_if.sv
// -----------------------------------------------------------------------------
// apb_i2c_sequencer_if
// APB bus bundle between the sequencer (master) and the APB-to-I2C bridge
// (slave).
//   psel, penable, pwrite : APB transfer controls, driven by the master
//   paddr, pwdata         : 32-bit address / write data, driven by the master
//   prdata                : 32-bit read data, driven by the slave
//   pready, pslverr       : transfer completion / error, driven by the slave
// -----------------------------------------------------------------------------
interface apb_i2c_sequencer_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_i2c_sequencer.sv
// -----------------------------------------------------------------------------
// apb_i2c_sequencer
// APB master feeding the APB-to-I2C bridge. Two requesters (0 = config/timeout,
// 1 = TX/RX data) are arbitrated round-robin; each accepted legal command
// becomes one APB SETUP/ACCESS transfer, illegal commands are answered locally
// with an error. The response goes back to the requester that issued it.
//   pclk, preset          : clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata : command from requester N
//   reqN_ready            : one-cycle acceptance pulse (decoded in IDLE)
//   rspN_valid/rdata/err  : one-cycle registered response to requester N
//   apb                   : APB master port
//   busy                  : high whenever the sequencer is not IDLE
//   err_count             : saturating count of error responses
// -----------------------------------------------------------------------------
module apb_i2c_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      req0_valid,
   input  logic                      req0_write,
   input  logic [31:0]               req0_addr,
   input  logic [31:0]               req0_wdata,
   output logic                      req0_ready,
   input  logic                      req1_valid,
   input  logic                      req1_write,
   input  logic [31:0]               req1_addr,
   input  logic [31:0]               req1_wdata,
   output logic                      req1_ready,
   output logic                      rsp0_valid,
   output logic [31:0]               rsp0_rdata,
   output logic                      rsp0_err,
   output logic                      rsp1_valid,
   output logic [31:0]               rsp1_rdata,
   output logic                      rsp1_err,
   apb_i2c_sequencer_if.master       apb,
   output logic                      busy,
   output logic [7:0]                err_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   // Only these four address/direction pairs exist on the bridge.
   function automatic logic is_legal(input logic wr, input logic [31:0] addr);
      logic ok;
      ok = 1'b0;
      case (addr)
         32'd0:   ok = wr;
         32'd4:   ok = ~wr;
         32'd8:   ok = wr;
         32'd12:  ok = wr;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_e      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_grant_q, last_grant_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        busy_q, busy_d;

   logic [1:0]  req_ready_s;
   logic        sel_s;
   logic        cmd_write_s;
   logic [31:0] cmd_addr_s;
   logic [31:0] cmd_wdata_s;

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      wait_cnt_d   = wait_cnt_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      err_count_d  = err_count_q;
      req_ready_s  = 2'b00;

      // Round-robin pick: on a tie the requester not served last wins.
      if (req0_valid && req1_valid) begin
         sel_s = ~last_grant_q;
      end else if (req1_valid) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
      cmd_write_s = sel_s ? req1_write : req0_write;
      cmd_addr_s  = sel_s ? req1_addr  : req0_addr;
      cmd_wdata_s = sel_s ? req1_wdata : req0_wdata;

      case (state_q)
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               // READY is a Mealy pulse so acceptance lands in the IDLE cycle.
               req_ready_s[sel_s] = 1'b1;
               gnt_d              = sel_s;
               last_grant_d       = sel_s;
               if (is_legal(cmd_write_s, cmd_addr_s)) begin
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = cmd_write_s;
                  paddr_d   = cmd_addr_s;
                  pwdata_d  = cmd_wdata_s;
                  state_d   = ST_SETUP;
               end else begin
                  // Rejected locally: APB lines keep their previous values.
                  rsp0_valid_d = ~sel_s;
                  rsp1_valid_d = sel_s;
                  rsp_rdata_d  = 32'd0;
                  rsp_err_d    = 1'b1;
                  state_d      = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            penable_d  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb.pready) begin
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               rsp0_valid_d = ~gnt_q;
               rsp1_valid_d = gnt_q;
               rsp_rdata_d  = pwrite_q ? 32'd0 : apb.prdata;
               rsp_err_d    = apb.pslverr;
               state_d      = ST_RESP;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // ACCESS has lasted TIMEOUT_CYCLES cycles: abandon the transfer.
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               rsp0_valid_d = ~gnt_q;
               rsp1_valid_d = gnt_q;
               rsp_rdata_d  = 32'd0;
               rsp_err_d    = 1'b1;
               state_d      = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_err_q && (err_count_q != 8'hFF)) begin
               err_count_d = err_count_q + 8'd1;
            end else begin
               err_count_d = err_count_q;
            end
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= ST_IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= 32'd0;
         pwdata_q     <= 32'd0;
         wait_cnt_q   <= 8'd0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_rdata_q  <= 32'd0;
         rsp_err_q    <= 1'b0;
         err_count_q  <= 8'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         wait_cnt_q   <= wait_cnt_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         err_count_q  <= err_count_d;
         busy_q       <= busy_d;
      end
   end

   assign req0_ready  = req_ready_s[0];
   assign req1_ready  = req_ready_s[1];
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_rdata  = rsp_rdata_q;
   assign rsp1_rdata  = rsp_rdata_q;
   assign rsp0_err    = rsp_err_q;
   assign rsp1_err    = rsp_err_q;
   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign busy        = busy_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_i2c_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apb_i2c_sequencer
// Scoreboard bench: drivers push the expected response (derived from the
// address/direction rules and the slave behaviour chosen for the transfer)
// when a command is accepted; a monitor pops and compares on every response.
// -----------------------------------------------------------------------------
module tb_apb_i2c_sequencer;
   localparam int T = 16;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc_len;
      int          acc_cyc;
   } exp_t;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   logic        req0_valid = 1'b0, req0_write = 1'b0;
   logic [31:0] req0_addr = 32'd0, req0_wdata = 32'd0;
   logic        req1_valid = 1'b0, req1_write = 1'b0;
   logic [31:0] req1_addr = 32'd0, req1_wdata = 32'd0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        busy;
   logic [7:0]  err_count;

   apb_i2c_sequencer_if apb_if ();

   apb_i2c_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .pclk(pclk), .preset(preset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .apb(apb_if.master), .busy(busy), .err_count(err_count)
   );

   always #5 pclk = ~pclk;

   int          cyc = 0;
   int          total_cnt = 0;
   int          pass_cnt = 0;
   exp_t        sb[$];
   int          acc_order[$];
   int          acc_cycles[$];
   int          pen_cnt = 0;
   int          mdl_err = 0;
   int          cfg_waits = 0;
   logic        cfg_slverr = 1'b0;
   logic [31:0] cfg_prdata = 32'd0;
   logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0;
   logic        cur_write = 1'b0;
   int          cur_acc_cyc = 0;

   initial begin
      forever begin
         @(posedge pclk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      if (act === exp) begin
         pass_cnt = pass_cnt + 1;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: the bridge only accepts these address/direction pairs.
   function automatic bit legal_cmd(input logic wr, input logic [31:0] addr);
      return (wr && (addr == 32'd0 || addr == 32'd8 || addr == 32'd12)) ||
             (!wr && addr == 32'd4);
   endfunction

   // APB slave: PREADY after cfg_waits wait states; PREADY also raised in
   // SETUP and noise on PRDATA/PSLVERR while not ready, none of which may matter.
   initial begin
      int acc_cnt;
      acc_cnt = 0;
      apb_if.pready = 1'b0; apb_if.prdata = 32'd0; apb_if.pslverr = 1'b0;
      forever begin
         @(negedge pclk);
         if (apb_if.psel && apb_if.penable) begin
            if (acc_cnt == cfg_waits) begin
               apb_if.pready = 1'b1; apb_if.prdata = cfg_prdata; apb_if.pslverr = cfg_slverr;
            end else begin
               apb_if.pready = 1'b0; apb_if.prdata = $urandom; apb_if.pslverr = 1'($urandom);
            end
            acc_cnt = acc_cnt + 1;
         end else begin
            acc_cnt = 0;
            apb_if.pready = apb_if.psel;
            apb_if.prdata = $urandom;
            apb_if.pslverr = 1'($urandom);
         end
      end
   end

   // Requester driver: waits for READY, then records the expected outcome.
   task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic slverr,
                        input logic [31:0] rdval, input bit expect_rsp);
      bit   got;
      exp_t e;
      @(posedge pclk); #1;
      if (port == 0) begin
         req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
      end else begin
         req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
      end
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge pclk);
         got = (port == 0) ? req0_ready : req1_ready;
      end
      chk("ready_seen", 32'(got), 32'd1);
      if (got) begin
         cfg_waits = waits; cfg_slverr = slverr; cfg_prdata = rdval;
         cur_addr = addr; cur_write = wr; cur_wdata = wdata; cur_acc_cyc = cyc;
         acc_order.push_back(port);
         acc_cycles.push_back(cyc);
         e.port = port; e.acc_cyc = cyc;
         if (!legal_cmd(wr, addr)) begin
            e.rdata = 32'd0; e.err = 1'b1; e.lat = 1; e.acc_len = 0;
         end else if (waits >= T) begin
            e.rdata = 32'd0; e.err = 1'b1; e.lat = T + 2; e.acc_len = T;
         end else begin
            e.rdata = wr ? 32'd0 : rdval; e.err = slverr;
            e.lat = waits + 3; e.acc_len = waits + 1;
         end
         if (expect_rsp) sb.push_back(e);
      end
      @(posedge pclk); #1;
      if (port == 0) req0_valid = 1'b0;
      else           req1_valid = 1'b0;
   endtask

   // Monitor: APB SETUP contents, ACCESS length, and every response.
   initial begin
      exp_t e;
      int   p;
      forever begin
         @(negedge pclk);
         if (preset) begin
            pen_cnt = 0;
            mdl_err = 0;
         end else begin
            if (apb_if.psel && !apb_if.penable) begin
               chk("setup_paddr", apb_if.paddr, cur_addr);
               chk("setup_pwrite", 32'(apb_if.pwrite), 32'(cur_write));
               chk("setup_pwdata", apb_if.pwdata, cur_wdata);
               chk("setup_cycle", 32'(cyc - cur_acc_cyc), 32'd1);
            end
            if (apb_if.psel && apb_if.penable) pen_cnt = pen_cnt + 1;
            if (rsp0_valid || rsp1_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  p = rsp1_valid ? 1 : 0;
                  chk("rsp_both_ports", 32'(rsp0_valid && rsp1_valid), 32'd0);
                  chk("rsp_port", 32'(p), 32'(e.port));
                  chk("rsp_rdata", (p == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
                  chk("rsp_err", 32'((p == 1) ? rsp1_err : rsp0_err), 32'(e.err));
                  chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                  chk("access_len", 32'(pen_cnt), 32'(e.acc_len));
                  chk("err_count", 32'(err_count), 32'(mdl_err));
                  if (e.err && mdl_err < 255) mdl_err = mdl_err + 1;
                  pen_cnt = 0;
               end
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge pclk);
         n = n + 1;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge pclk);
   endtask

   task automatic two_each(input int port, input logic wr, input logic [31:0] addr);
      for (int k = 0; k < 2; k++) begin
         issue(port, wr, addr, $urandom, 0, 1'b0, $urandom, 1'b1);
      end
   endtask

   initial begin
      int          w;
      logic [31:0] a;
      logic [31:0] addrs[6];
      addrs = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd2};

      // Reset state.
      repeat (3) @(posedge pclk);
      #1 preset = 1'b0;
      @(negedge pclk);
      chk("rst_psel", 32'(apb_if.psel), 32'd0);
      chk("rst_penable", 32'(apb_if.penable), 32'd0);
      chk("rst_pwrite", 32'(apb_if.pwrite), 32'd0);
      chk("rst_paddr", apb_if.paddr, 32'd0);
      chk("rst_pwdata", apb_if.pwdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("rst_rsp_data", rsp0_rdata | rsp1_rdata | 32'({rsp0_err, rsp1_err}), 32'd0);

      // Directed: config write, waited RX read.
      issue(0, 1'b1, 32'd8, 32'h0000_1234, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      drain();
      issue(1, 1'b0, 32'd4, 32'h0, 2, 1'b0, 32'hA5A5_5A5A, 1'b1);
      drain();

      // Tie for four commands: strict alternation, READY every 4 cycles.
      acc_order.delete(); acc_cycles.delete();
      fork
         two_each(0, 1'b1, 32'd8);
         two_each(1, 1'b0, 32'd4);
      join
      drain();
      chk("tie_count", 32'(acc_order.size()), 32'd4);
      if (acc_order.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("tie_order", 32'(acc_order[i]), 32'(i % 2));
            if (i > 0) chk("tie_spacing", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'd4);
         end
      end

      // Illegal direction/address pairs.
      issue(0, 1'b1, 32'd4, 32'h55, 0, 1'b0, 32'h0, 1'b1);
      issue(0, 1'b0, 32'd8, 32'h66, 0, 1'b0, 32'h0, 1'b1);
      drain();

      // Timeout, slave error, success on the last permitted cycle.
      issue(1, 1'b1, 32'd12, 32'h77, 255, 1'b0, 32'h0, 1'b1);
      issue(0, 1'b1, 32'd0, 32'h88, 0, 1'b1, 32'h0, 1'b1);
      issue(1, 1'b0, 32'd4, 32'h0, T - 1, 1'b0, 32'h1357_9BDF, 1'b1);
      drain();

      // Randomised mix.
      for (int i = 0; i < 40; i++) begin
         a = addrs[$urandom_range(0, 5)];
         case ($urandom_range(0, 7))
            0:       w = 255;
            1:       w = T - 1;
            default: w = $urandom_range(0, 3);
         endcase
         issue($urandom_range(0, 1), 1'($urandom), a, $urandom, w, 1'($urandom),
               $urandom, 1'b1);
      end
      drain();

      // Reset during ACCESS: no response, first tie afterwards goes to 0.
      issue(1, 1'b1, 32'd12, 32'h99, 255, 1'b0, 32'h0, 1'b0);
      repeat (3) @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      chk("midrst_psel", 32'(apb_if.psel), 32'd0);
      chk("midrst_penable", 32'(apb_if.penable), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      @(posedge pclk); #1 preset = 1'b0;
      repeat (T + 4) @(negedge pclk);
      acc_order.delete();
      fork
         issue(0, 1'b1, 32'd0, $urandom, 0, 1'b0, 32'h0, 1'b1);
         issue(1, 1'b1, 32'd8, $urandom, 0, 1'b0, 32'h0, 1'b1);
      join
      drain();
      chk("post_rst_tie", (acc_order.size() > 0) ? 32'(acc_order[0]) : 32'd9, 32'd0);

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++) begin
         issue(i % 2, 1'b0, 32'd12, 32'h0, 0, 1'b0, 32'h0, 1'b1);
      end
      drain();
      chk("err_count_sat", 32'(err_count), 32'(mdl_err));
      chk("err_count_255", 32'(mdl_err), 32'd255);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
